param_serializer: RTL and testbench

Parametrised parallel-to-serial shifter for the UART TX path, successor to the fixed 8-bit serializer. Converts a DATA_WIDTH-bit word into a bit stream under control of the TX FSM via `ser_en`. Adds:
- per-word LSB/MSB-first selection;
- a one-word holding buffer with valid/ready handshake, so consecutive frames can be fed without gaps;
- optional parity generation.

---
 rtl/param_serializer_if.sv | 23 ++
 rtl/param_serializer.sv | 162 ++++++++++++++++
 tb/tb_param_serializer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/param_serializer_if.sv
// Word-offer channel into param_serializer: parallel word plus per-word order/parity controls.
// Latency: none, pure signal bundle.
// Backpressure: Data_Ready from the serializer; a word is taken on an edge with Data_Valid && Data_Ready.
// Build macro: SER_PARITY_EN adds par_type (0 = even, 1 = odd) to the channel.
interface param_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  msb_first;
  logic                  Data_Ready;
`ifdef SER_PARITY_EN
  logic                  par_type;

  modport master (output P_DATA, output Data_Valid, output msb_first, output par_type,
                  input  Data_Ready);
  modport slave  (input  P_DATA, input  Data_Valid, input  msb_first, input  par_type,
                  output Data_Ready);
`else
  modport master (output P_DATA, output Data_Valid, output msb_first, input  Data_Ready);
  modport slave  (input  P_DATA, input  Data_Valid, input  msb_first, output Data_Ready);
`endif
endinterface

// File: rtl/param_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer for gapless back-to-back frames.
// Latency: first bit on ser_data the cycle after acceptance in IDLE; a held word follows with zero gap.
// Backpressure: Data_Ready = !hold_full; ser_en low freezes the shifter (hold may still fill).
// Ports: CLK, RST (sync, active-high); in_if (P_DATA, Data_Valid, msb_first, Data_Ready[, par_type]);
//        ser_en in; ser_data, ser_done, busy out (all registered)[; par_bit out].
// Build macro: SER_PARITY_EN enables par_type/par_bit parity generation.
module param_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  param_serializer_if.slave  in_if,
  input  logic               ser_en,
  output logic               ser_data,
  output logic               ser_done,
  output logic               busy
`ifdef SER_PARITY_EN
  ,
  output logic               par_bit
`endif
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_LOADED} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_word_q, sh_word_d;
  logic                  sh_msb_q, sh_msb_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_word_q, hold_word_d;
  logic                  hold_msb_q, hold_msb_d;
  logic                  hold_full_q, hold_full_d;
  logic                  ser_data_q, ser_data_d;
  logic                  ser_done_q, ser_done_d;
  logic                  busy_q, busy_d;

  logic accept, last_bit, load_in, load_hold, to_hold;

  function automatic logic sel_bit(input logic [DATA_WIDTH-1:0] w, input logic msb,
                                   input logic [CW-1:0] c);
    logic [CW-1:0] idx;
    idx = msb ? (LAST - c) : c;
    return w[idx];
  endfunction

  assign in_if.Data_Ready = !hold_full_q;

  always_comb begin
    accept    = in_if.Data_Valid && !hold_full_q;
    last_bit  = (state_q == S_LOADED) && ser_en && (cnt_q == LAST);
    load_hold = last_bit && hold_full_q;
    // A fresh word bypasses the hold register when the shifter is (or is just becoming) free.
    load_in   = accept && ((state_q == S_IDLE) || (last_bit && !hold_full_q));
    to_hold   = accept && !load_in;
  end

  always_comb begin
    state_d     = state_q;
    sh_word_d   = sh_word_q;
    sh_msb_d    = sh_msb_q;
    cnt_d       = cnt_q;
    hold_word_d = hold_word_q;
    hold_msb_d  = hold_msb_q;
    hold_full_d = hold_full_q;

    case (state_q)
      S_IDLE: if (load_in) state_d = S_LOADED;
      S_LOADED: if (last_bit && !load_hold && !load_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (last_bit) begin
      cnt_d = '0;
    end else if ((state_q == S_LOADED) && ser_en) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (load_hold) begin
      sh_word_d   = hold_word_q;
      sh_msb_d    = hold_msb_q;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else if (load_in) begin
      sh_word_d = in_if.P_DATA;
      sh_msb_d  = in_if.msb_first;
      cnt_d     = '0;
    end

    if (to_hold) begin
      hold_word_d = in_if.P_DATA;
      hold_msb_d  = in_if.msb_first;
      hold_full_d = 1'b1;
    end

    ser_done_d = last_bit;
    busy_d     = (state_d == S_LOADED);
    // Output register shows the bit that the next ser_en cycle will consume.
    ser_data_d = (state_d == S_LOADED) ? sel_bit(sh_word_d, sh_msb_d, cnt_d) : 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      sh_word_q   <= '0;
      sh_msb_q    <= 1'b0;
      cnt_q       <= '0;
      hold_word_q <= '0;
      hold_msb_q  <= 1'b0;
      hold_full_q <= 1'b0;
      ser_data_q  <= 1'b1;
      ser_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_word_q   <= sh_word_d;
      sh_msb_q    <= sh_msb_d;
      cnt_q       <= cnt_d;
      hold_word_q <= hold_word_d;
      hold_msb_q  <= hold_msb_d;
      hold_full_q <= hold_full_d;
      ser_data_q  <= ser_data_d;
      ser_done_q  <= ser_done_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_data = ser_data_q;
  assign ser_done = ser_done_q;
  assign busy     = busy_q;

`ifdef SER_PARITY_EN
  // Parity follows the word into the hold register so it is ready at the zero-gap transfer.
  logic hold_par_q, hold_par_d;
  logic par_bit_q, par_bit_d;

  always_comb begin
    hold_par_d = hold_par_q;
    par_bit_d  = par_bit_q;
    if (to_hold) hold_par_d = in_if.par_type;
    if (load_hold) begin
      par_bit_d = (^hold_word_q) ^ hold_par_q;
    end else if (load_in) begin
      par_bit_d = (^in_if.P_DATA) ^ in_if.par_type;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_par_q <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      hold_par_q <= hold_par_d;
      par_bit_q  <= par_bit_d;
    end
  end

  assign par_bit = par_bit_q;
`endif

endmodule

// File: tb/tb_param_serializer.sv
module tb_param_serializer;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST;
  logic ser_en, ser_data, ser_done, busy;
`ifdef SER_PARITY_EN
  logic par_bit;
`endif

  always #5 CLK = ~CLK;

  param_serializer_if #(.DATA_WIDTH(W)) bus ();

  param_serializer #(.DATA_WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_if    (bus),
    .ser_en   (ser_en),
    .ser_data (ser_data),
    .ser_done (ser_done),
    .busy     (busy)
`ifdef SER_PARITY_EN
    ,
    .par_bit  (par_bit)
`endif
  );

  // Reference model: the expected future line as a queue of {last_of_word, bit}.
  logic [1:0] bitq[$];
  logic       parq[$];
  logic       exp_par;
  logic       exp_done;
  int         ncmp = 0;
  int         nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs, advance the model by one edge, then check after it.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d,
                      input logic m, input logic p, input logic en);
    logic       acc;
    logic [1:0] e;
    RST            = rst;
    bus.Data_Valid = v;
    bus.P_DATA     = d;
    bus.msb_first  = m;
`ifdef SER_PARITY_EN
    bus.par_type   = p;
`endif
    ser_en         = en;
    acc = v && (bitq.size() <= W);
    if (rst) begin
      bitq.delete();
      parq.delete();
      exp_par  = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (en && bitq.size() > 0) begin
        e = bitq.pop_front();
        if (e[1]) begin
          exp_done = 1'b1;
          void'(parq.pop_front());
        end
      end
      if (acc) begin
        for (int i = 0; i < W; i++) bitq.push_back({(i == W - 1), (m ? d[W-1-i] : d[i])});
        parq.push_back((^d) ^ p);
      end
      if (parq.size() > 0) exp_par = parq[0];
    end
    @(negedge CLK);
    check("ser_data",   ser_data,       (bitq.size() > 0) ? bitq[0][0] : 1'b1);
    check("ser_done",   ser_done,       exp_done);
    check("busy",       busy,           bitq.size() > 0);
    check("Data_Ready", bus.Data_Ready, bitq.size() <= W);
`ifdef SER_PARITY_EN
    check("par_bit",    par_bit,        exp_par);
`endif
  endtask

  logic [15:0] seq;
  int          d1, d2;

  initial begin
    RST = 1'b1; ser_en = 1'b0;
    bus.Data_Valid = 1'b0; bus.P_DATA = '0; bus.msb_first = 1'b0;
`ifdef SER_PARITY_EN
    bus.par_type = 1'b0;
`endif
    exp_par = 1'b0; exp_done = 1'b0;
    @(negedge CLK);
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);

    // Reset mid-word
    step(0, 1, 8'h5A, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0, 1);
    check("rst_ser_data", ser_data, 1'b1);
    check("rst_ser_done", ser_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", bus.Data_Ready, 1'b1);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0, 0, 1);

    // LSB first 0xC1
    step(0, 1, 8'hC1, 0, 0, 1);
    check("lsb_first_bit", ser_data, 1'b1);
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      seq[i] = ser_data;
      step(0, 0, 8'h00, 0, 0, 1);
      if (i < 7) check("lsb_no_early_done", ser_done, 1'b0);
    end
    check("lsb_done", ser_done, 1'b1);
    check("lsb_busy_fall", busy, 1'b0);
    check("lsb_seq", seq[7:0], 8'hC1);
    step(0, 0, 8'h00, 0, 0, 1);

    // MSB first 0xC1 with msb_first toggling mid-word
    step(0, 1, 8'hC1, 1, 0, 0);
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      seq[i] = ser_data;
      step(0, 0, 8'h00, i[0], 0, 1);
    end
    check("msb_done", ser_done, 1'b1);
    check("msb_seq", seq[7:0], 8'h83);
    step(0, 0, 8'h00, 0, 0, 0);

    // Back-to-back 0x0F then 0xF0
    step(0, 1, 8'h0F, 0, 0, 0);
    seq = '0; d1 = -1; d2 = -1;
    for (int i = 0; i < 16; i++) begin
      seq[i] = ser_data;
      step(0, (i == 0), 8'hF0, 0, 0, 1);
      if (i < 7) check("b2b_ready_low", bus.Data_Ready, 1'b0);
      if (ser_done && d1 < 0) d1 = i;
      else if (ser_done) d2 = i;
    end
    check("b2b_seq", seq, 16'hF00F);
    check("b2b_first_done", d1, 7);
    check("b2b_done_gap", d2 - d1, 8);
    step(0, 0, 8'h00, 0, 0, 1);

    // Pause after the 3rd bit of 0xA5
    step(0, 1, 8'hA5, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 0, 0, 0);
      check("pause_hold", ser_data, 1'b0);
    end
    seq = '0;
    for (int i = 0; i < 5; i++) begin
      seq[i] = ser_data;
      step(0, 0, 8'h00, 0, 0, 1);
      if (i < 4) check("pause_no_early_done", ser_done, 1'b0);
    end
    check("pause_tail", seq[4:0], 5'b10100);
    check("pause_done", ser_done, 1'b1);

`ifdef SER_PARITY_EN
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 8'h07, 0, k[0], 0);
      for (int i = 0; i < 8; i++) begin
        check("parity_07", par_bit, (k == 0) ? 1'b1 : 1'b0);
        step(0, 0, 8'h00, 0, 0, 1);
      end
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0), $urandom_range(0, 1), W'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 2 * W + 2; i++) step(0, 0, 8'h00, 0, 0, 1);
    check("drain_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
